// File: rtl/div47_pkg.sv
// Shared constants and FSM state type for the divide-by-47 family.
// Used by the reconstructing multiplier and its digit multiplier.
package div47_pkg;

  localparam int DIVISOR    = 47;
  localparam int Q_W        = 55;
  localparam int R_W        = 6;
  localparam int X_W        = 60;
  localparam int DIGIT_W    = 6;
  localparam int NUM_DIGITS = 10;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_digit_47.sv
// Constant multiplier: one quotient digit times 47.
// 47*d = 64*d - 16*d - d, no hard multiplier needed.
module mul_digit_47
  import div47_pkg::*;
(
  input  logic [DIGIT_W-1:0]   d,
  output logic [2*DIGIT_W-1:0] p
);

  logic [2*DIGIT_W-1:0] d64;
  logic [2*DIGIT_W-1:0] d16;
  logic [2*DIGIT_W-1:0] d1;

  // Shift-add form; 63*47 still fits in 12 bits.
  always_comb begin
    d64 = {d, {DIGIT_W{1'b0}}};
    d16 = {{(DIGIT_W-4){1'b0}}, d, 4'b0};
    d1  = {{DIGIT_W{1'b0}}, d};
    p   = d64 - d16 - d1;
  end

endmodule

// File: rtl/mul_60_47.sv
// Reconstructs x = q*47 + r one 6-bit digit per cycle, MS first.
// Valid/ready on both sides; result held stable until taken.
module mul_60_47
  import div47_pkg::*;
#(
  parameter int DIVISOR = div47_pkg::DIVISOR,
  parameter int Q_W     = div47_pkg::Q_W,
  parameter int R_W     = div47_pkg::R_W,
  parameter int X_W     = div47_pkg::X_W,
  parameter int DIGIT_W = div47_pkg::DIGIT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] q_in,
  input  logic [R_W-1:0] r_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] x_out,
  output logic           ovf,
  output logic           r_err
);

  localparam int ACC_W = X_W + 1;

  state_t             state;
  logic [Q_W-1:0]     q_reg;
  logic [R_W-1:0]     r_reg;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;

  logic [Q_W-1:0]       q_sh;
  logic [DIGIT_W-1:0]   digit;
  logic [2*DIGIT_W-1:0] prod;
  logic [ACC_W-1:0]     addend;
  logic [ACC_W-1:0]     acc_next;

  // Top digit is the lone MSB; a shift of 54 leaves just that bit.
  always_comb begin
    q_sh     = q_reg >> (int'(idx) * DIGIT_W);
    digit    = q_sh[DIGIT_W-1:0];
    addend   = (idx == '0) ? ACC_W'(r_reg) : '0;
    acc_next = (acc << DIGIT_W) + ACC_W'(prod) + addend;
  end

  mul_digit_47 u_digit (
    .d (digit),
    .p (prod)
  );

  assign in_ready = (state == S_IDLE);

  // Control FSM with accumulator and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      x_out     <= '0;
      ovf       <= 1'b0;
      r_err     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            q_reg <= q_in;
            r_reg <= r_in;
            r_err <= ((R_W+1)'(r_in) >= (R_W+1)'(DIVISOR));
            acc   <= '0;
            idx   <= IDX_W'(NUM_DIGITS - 1);
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (idx == '0) begin
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            x_out     <= acc[X_W-1:0];
            ovf       <= acc[X_W];
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_60_47.sv
// Scoreboard bench for mul_60_47: directed vectors, latency,
// backpressure and mid-run reset.
module tb_mul_60_47;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [54:0] q_in;
  logic [5:0]  r_in;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] x_out;
  logic        ovf;
  logic        r_err;

  typedef struct packed {
    logic [59:0] x;
    logic        ovf;
    logic        rerr;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  exp_t want;
  int   checks = 0;
  int   errors = 0;

  mul_60_47 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .ovf       (ovf),
    .r_err     (r_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: x=%0d", x_out);
      end else begin
        want = sb.pop_front();
        got  = '{x: x_out, ovf: ovf, rerr: r_err};
        if (got !== want) begin
          errors++;
          $display("FAIL result: got x=%0d ovf=%0b rerr=%0b expected x=%0d ovf=%0b rerr=%0b",
                   got.x, got.ovf, got.rerr, want.x, want.ovf, want.rerr);
        end
      end
    end
  end

  task automatic accept(input logic [54:0] q, input logic [5:0] r,
                        input logic [59:0] x, input logic o,
                        input logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    q_in     = q;
    r_in     = r;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{x: x, ovf: o, rerr: e});
    #1;
    in_valid = 1'b0;
    q_in     = '1;
    r_in     = '1;
  endtask

  task automatic run(input logic [54:0] q, input logic [5:0] r,
                     input logic [59:0] x, input logic o,
                     input logic e);
    int lat;
    accept(q, r, x, o, e);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd11);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q_in      = '0;
    r_in      = '0;
    #12;
    check("rst_x", 64'(x_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_rerr", 64'(r_err), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    run(55'd0, 6'd0, 60'd0, 1'b0, 1'b0);
    run(55'd1, 6'd46, 60'd93, 1'b0, 1'b0);
    run(55'd24530244778869084, 6'd27,
        60'd1152921504606846975, 1'b0, 1'b0);
    run(55'd24530244778869085, 6'd0, 60'd19, 1'b1, 1'b0);
    run(55'd5, 6'd47, 60'd282, 1'b0, 1'b1);
    run(55'd64, 6'd0, 60'd3008, 1'b0, 1'b0);
    run({55{1'b1}}, 6'd63, 60'd540431955284459536, 1'b1, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    run(55'd1000, 6'd7, 60'd47007, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_x", 64'(x_out), 64'd47007);
      check("bp_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of RUN discards the operation.
    accept(55'd123456, 6'd50, 60'd0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", 64'(x_out), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rerr", 64'(r_err), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", 64'(seen), 64'd0);
    run(55'd3, 6'd2, 60'd143, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
